disp_src_arbiter: RTL

DISP_SRC_ARBITER -- requirements
Module: disp_src_arbiter

---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_tick_timer.sv | 36 +++
 rtl/disp_src_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display source arbiter.
// Holds the FSM state enum, the source encoding and the blank digit pattern.
package disp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMeas,
        StBanner,
        StErrOn,
        StErrOff
    } disp_state_e;

    typedef enum logic [1:0] {
        SrcNone   = 2'd0,
        SrcMeas   = 2'd1,
        SrcBanner = 2'd2,
        SrcErr    = 2'd3
    } disp_src_e;

    localparam logic [15:0] BLANK_CODE = 16'hFFFF;

    // Milliseconds to clock cycles, clamped so a timer always runs at least one cycle.
    function automatic int unsigned ms_to_cyc(input int unsigned freq_hz, input int unsigned ms);
        int unsigned cyc;
        cyc = (freq_hz / 32'd1000) * ms;
        return (cyc == 32'd0) ? 32'd1 : cyc;
    endfunction

endpackage

// File: rtl/disp_tick_timer.sv
// Loadable down-counter that stops at zero; load wins over counting.
// Used for both the banner hold time and the error blink half-period.
module disp_tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/disp_src_arbiter.sv
// Selects what the display shows: error (blinking) > banner (timed) > measurement > blank.
// All display outputs are registered one cycle behind the FSM state.
module disp_src_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 100_000_000,
    parameter int unsigned BANNER_MS     = 1000,
    parameter int unsigned BLINK_MS      = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        meas_vld,
    input  logic [15:0] meas_bcd,
    input  logic [3:0]  meas_dp,
    input  logic        bnr_req,
    input  logic [15:0] bnr_bcd,
    input  logic [3:0]  bnr_dp,
    input  logic        err_act,
    input  logic [15:0] err_code,
    output logic [15:0] disp_x,
    output logic [3:0]  disp_dp,
    output logic        disp_en,
    output logic [1:0]  src,
    output logic        bnr_busy
);

    localparam int unsigned BANNER_CYC = ms_to_cyc(CLOCK_FREQ_HZ, BANNER_MS);
    localparam int unsigned BLINK_CYC  = ms_to_cyc(CLOCK_FREQ_HZ, BLINK_MS);
    localparam int unsigned BNR_W      = $clog2(BANNER_CYC + 1);
    localparam int unsigned BLK_W      = $clog2(BLINK_CYC + 1);

    disp_state_e state_q, state_d;

    logic [15:0] meas_bcd_q, bnr_bcd_q;
    logic [3:0]  meas_dp_q, bnr_dp_q;
    logic        meas_seen_q, meas_seen_d;

    logic [15:0] disp_x_q, disp_x_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    disp_src_e   src_q, src_d;
    logic        disp_en_q;

    logic [BNR_W-1:0] bnr_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic             bnr_zero, blk_zero;
    logic             blk_load;
    logic             bnr_live;
    logic             blk_expire;

    disp_tick_timer #(
        .WIDTH (BNR_W)
    ) u_bnr_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (bnr_req),
        .load_val (BNR_W'(BANNER_CYC)),
        .cnt      (bnr_cnt),
        .zero     (bnr_zero)
    );

    disp_tick_timer #(
        .WIDTH (BLK_W)
    ) u_blk_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (blk_load),
        .load_val (BLK_W'(BLINK_CYC)),
        .cnt      (blk_cnt),
        .zero     (blk_zero)
    );

    // Decisions use next-cycle views so the banner lasts exactly BANNER_CYC cycles
    // and a fresh measurement is shown two cycles after its strobe.
    assign meas_seen_d = meas_seen_q | meas_vld;
    assign bnr_live    = bnr_req | (bnr_cnt > BNR_W'(1));
    assign blk_expire  = blk_zero | (blk_cnt == BLK_W'(1));

    always_comb begin
        state_d  = state_q;
        blk_load = 1'b0;
        unique case (state_q)
            StIdle, StMeas, StBanner: begin
                if (err_act) begin
                    state_d  = StErrOn;
                    blk_load = 1'b1;
                end else if (bnr_live) begin
                    state_d = StBanner;
                end else if (meas_seen_d) begin
                    state_d = StMeas;
                end else begin
                    state_d = StIdle;
                end
            end
            StErrOn, StErrOff: begin
                if (!err_act) begin
                    if (bnr_live) begin
                        state_d = StBanner;
                    end else if (meas_seen_d) begin
                        state_d = StMeas;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (blk_expire) begin
                    state_d  = (state_q == StErrOn) ? StErrOff : StErrOn;
                    blk_load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        disp_x_d  = BLANK_CODE;
        disp_dp_d = '0;
        src_d     = SrcNone;
        case (state_q)
            StMeas: begin
                disp_x_d  = meas_bcd_q;
                disp_dp_d = meas_dp_q;
                src_d     = SrcMeas;
            end
            StBanner: begin
                disp_x_d  = bnr_bcd_q;
                disp_dp_d = bnr_dp_q;
                src_d     = SrcBanner;
            end
            StErrOn: begin
                disp_x_d = err_code;
                src_d    = SrcErr;
            end
            StErrOff: begin
                src_d = SrcErr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            meas_bcd_q  <= BLANK_CODE;
            meas_dp_q   <= '0;
            bnr_bcd_q   <= BLANK_CODE;
            bnr_dp_q    <= '0;
            meas_seen_q <= 1'b0;
            disp_x_q    <= BLANK_CODE;
            disp_dp_q   <= '0;
            src_q       <= SrcNone;
            disp_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            meas_seen_q <= meas_seen_d;
            if (meas_vld) begin
                meas_bcd_q <= meas_bcd;
                meas_dp_q  <= meas_dp;
            end
            if (bnr_req) begin
                bnr_bcd_q <= bnr_bcd;
                bnr_dp_q  <= bnr_dp;
            end
            disp_x_q  <= disp_x_d;
            disp_dp_q <= disp_dp_d;
            src_q     <= src_d;
            disp_en_q <= 1'b1;
        end
    end

    assign disp_x   = disp_x_q;
    assign disp_dp  = disp_dp_q;
    assign src      = src_q;
    assign disp_en  = disp_en_q;
    assign bnr_busy = ~bnr_zero;

endmodule
